fetch_controller: RTL

Sequences the instruction memory for the processor core. Owns the program counter, drives the memory address, and registers each fetched word into a one-entry output buffer with a valid/ready handshake to the decode stage. Accepts branch redirects from the datapath, stalls on input instructions until external input arrives, stops on halt, and flags out-of-range fetches.

---
 rtl/fetch_controller_pkg.sv | 35 +++
 rtl/fetch_controller_if.sv | 32 +++
 rtl/fetch_controller_opcode_classifier.sv | 21 ++
 rtl/fetch_controller.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg
// Shared constants for the fetch controller slice: instruction field
// positions, opcode values, FSM state encoding and a field-extract helper.
// No ports.
package fetch_controller_pkg;

  typedef logic [4:0] opcode_t;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int IMM_MSB = 16;
  localparam int IMM_LSB = 0;

  localparam opcode_t OP_NOP  = 5'b00100;
  localparam opcode_t OP_HALT = 5'b00110;
  localparam opcode_t OP_IN   = 5'b01100;
  localparam opcode_t OP_OUT  = 5'b01101;
  localparam opcode_t OP_BEQ  = 5'b00111;
  localparam opcode_t OP_BLT  = 5'b01000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_WAIT_IN = 3'd2;
  localparam logic [2:0] ST_HALT    = 3'd3;
  localparam logic [2:0] ST_FAULT   = 3'd4;

  function automatic opcode_t get_opcode(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if
// Groups the instruction-memory bus, the decode-side valid/ready buffer,
// the branch redirect and the external-input strobe.
//   imem_address/imem_data  : word address out, same-cycle read data in
//   instr_out/instr_pc      : buffered word and its fetch address
//   instr_valid/instr_ready : decode handshake
//   redirect_valid/target   : taken-branch pulse and absolute target
//   input_valid             : external input word available
// master = fetch controller, slave = memory/decode/datapath side.
interface fetch_controller_if;

  logic [31:0] imem_address;
  logic [31:0] imem_data;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        input_valid;

  modport master (
    output imem_address, instr_out, instr_pc, instr_valid,
    input  imem_data, instr_ready, redirect_valid, redirect_target, input_valid
  );

  modport slave (
    input  imem_address, instr_out, instr_pc, instr_valid,
    output imem_data, instr_ready, redirect_valid, redirect_target, input_valid
  );

endinterface

// File: rtl/fetch_controller_opcode_classifier.sv
// opcode_classifier
// Combinational decode of the fetched opcode into the three classes the
// fetch FSM reacts to.
//   i_opcode  : opcode field of the word on the memory bus
//   o_is_nop  : nop
//   o_is_halt : halt
//   o_is_in   : input (stalls fetch until external input arrives)
module opcode_classifier
  import fetch_controller_pkg::*;
(
  input  opcode_t i_opcode,
  output logic    o_is_nop,
  output logic    o_is_halt,
  output logic    o_is_in
);

  assign o_is_nop  = (i_opcode == OP_NOP);
  assign o_is_halt = (i_opcode == OP_HALT);
  assign o_is_in   = (i_opcode == OP_IN);

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller
// Owns the program counter, drives instruction-memory addresses and keeps a
// one-entry output buffer toward decode. Handles branch redirects, input
// stalls, halt and out-of-range fetch faults.
// Optional build macro: FETCH_NOP_SQUASH_EN -- nop words are skipped
// instead of buffered (pc still advances, one cycle per nop).
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high
//   i_run    : leave IDLE when high
//   o_halted : halt word has been accepted by decode
//   o_fault  : out-of-range fetch seen, sticky until reset
//   bus      : fetch_controller_if.master (memory, decode, redirect, input)
//
// state      | meaning
// ST_IDLE    | waiting for run, no fetch
// ST_FETCH   | presenting pc, loading buffer when it has room
// ST_WAIT_IN | input word fetched, waiting for input_valid
// ST_HALT    | halt word fetched; halted once it handshakes
// ST_FAULT   | pc went out of range, buffer drains, no fetch
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 31,
  parameter logic [31:0] START_PC  = 32'd0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_run,
  output logic               o_halted,
  output logic               o_fault,
  fetch_controller_if.master bus
);

`ifdef FETCH_NOP_SQUASH_EN
  localparam bit NOP_SQUASH = 1'b1;
`else
  localparam bit NOP_SQUASH = 1'b0;
`endif

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr_out;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_halted;
  logic        r_fault;

  logic w_is_nop, w_is_halt, w_is_in;
  logic w_fetching, w_hs, w_oob, w_redir, w_squash, w_load;

  opcode_classifier u_classifier (
    .i_opcode  (get_opcode(bus.imem_data)),
    .o_is_nop  (w_is_nop),
    .o_is_halt (w_is_halt),
    .o_is_in   (w_is_in)
  );

  assign w_fetching = (r_state == ST_FETCH);
  assign w_hs       = r_instr_valid && bus.instr_ready;
  assign w_oob      = (r_pc >= MEM_DEPTH);
  // Once the halt word has been accepted the core is stopped for good, so
  // a late redirect must not restart fetching.
  assign w_redir    = bus.redirect_valid &&
                      (w_fetching || (r_state == ST_WAIT_IN) ||
                       ((r_state == ST_HALT) && !r_halted));
  assign w_squash   = w_fetching && !w_oob && NOP_SQUASH && w_is_nop;
  // Load when the buffer is empty or being emptied this same cycle.
  assign w_load     = w_fetching && !w_oob && !w_squash &&
                      (!r_instr_valid || w_hs);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= START_PC;
      r_instr_out   <= 32'd0;
      r_instr_pc    <= 32'd0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else if (w_redir) begin
      // Flush even a word handshaking this cycle; decode discards it.
      r_instr_valid <= 1'b0;
      r_pc          <= bus.redirect_target;
      r_state       <= ST_FETCH;
    end else begin
      if (w_load) begin
        r_instr_out   <= bus.imem_data;
        r_instr_pc    <= r_pc;
        r_instr_valid <= 1'b1;
        r_pc          <= r_pc + 32'd1;
      end else if (w_hs) begin
        r_instr_valid <= 1'b0;
      end
      if (w_squash) begin
        r_pc <= r_pc + 32'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_run) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (w_oob) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end else if (w_load && w_is_halt) begin
            r_state <= ST_HALT;
          end else if (w_load && w_is_in) begin
            r_state <= ST_WAIT_IN;
          end
        end
        ST_WAIT_IN: begin
          if (bus.input_valid) r_state <= ST_FETCH;
        end
        ST_HALT: begin
          // The buffered word is the halt word: no loads happen in HALT.
          if (w_hs) r_halted <= 1'b1;
        end
        ST_FAULT: begin
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.imem_address = r_pc;
  assign bus.instr_out    = r_instr_out;
  assign bus.instr_pc     = r_instr_pc;
  assign bus.instr_valid  = r_instr_valid;
  assign o_halted         = r_halted;
  assign o_fault          = r_fault;

endmodule
